// File: rtl/ysyx_24110026_decode_stage_if.sv
// ----------------------------------------------------------------------------
// ysyx_24110026_decode_stage_if
// Bus bundle of the decode stage: IFU offer (in_*), regfile read port
// (rs*_addr / rs*_data_in), redirect (flush), EXU bundle (out_*) and the
// ebreak_call strobe that the simulation wrapper turns into the ebreak() call.
//   slave  : decode-stage view
//   master : environment view (IFU + regfile + EXU)
// ----------------------------------------------------------------------------
interface ysyx_24110026_decode_stage_if #(
  parameter int ALU_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_inst;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [31:0]      rs1_data_in;
  logic [31:0]      rs2_data_in;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_op1;
  logic [31:0]      out_op2;
  logic [31:0]      out_imm;
  logic [31:0]      out_rs2_data;
  logic [ALU_W-1:0] out_alu_op;
  logic [4:0]       out_rd_addr;
  logic             out_rd_wen;
  logic [2:0]       out_funct3;
  logic             out_is_load;
  logic             out_is_store;
  logic             out_is_branch;
  logic             out_is_jal;
  logic             out_is_jalr;
  logic             out_ebreak;
  logic             out_illegal;
  logic             ebreak_call;

  modport slave (
    input  in_valid, in_pc, in_inst, rs1_data_in, rs2_data_in, flush, out_ready,
    output in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_op1, out_op2,
           out_imm, out_rs2_data, out_alu_op, out_rd_addr, out_rd_wen, out_funct3,
           out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr,
           out_ebreak, out_illegal, ebreak_call
  );

  modport master (
    output in_valid, in_pc, in_inst, rs1_data_in, rs2_data_in, flush, out_ready,
    input  in_ready, rs1_addr, rs2_addr, out_valid, out_pc, out_op1, out_op2,
           out_imm, out_rs2_data, out_alu_op, out_rd_addr, out_rd_wen, out_funct3,
           out_is_load, out_is_store, out_is_branch, out_is_jal, out_is_jalr,
           out_ebreak, out_illegal, ebreak_call
  );
endinterface

// File: rtl/ysyx_24110026_decode_stage.sv
// ----------------------------------------------------------------------------
// ysyx_24110026_decode_stage
// RV32E/RV32I (+optional M) decode stage between IFU and EXU. Decodes the
// offered instruction, samples regfile operands on the accepting edge and
// holds the bundle in a two-slot (OUT + SKID) valid/ready buffer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : ysyx_24110026_decode_stage_if.slave (handshakes, regfile, bundle)
// ----------------------------------------------------------------------------
module ysyx_24110026_decode_stage #(
  parameter int NR_REG = 16,
  parameter int M_EXT  = 0,
  parameter int ALU_W  = 10 + 8 * M_EXT
) (
  input logic                         clk,
  input logic                         rst,
  ysyx_24110026_decode_stage_if.slave bus
);
  localparam logic [6:0] OPC_OP    = 7'h33;
  localparam logic [6:0] OPC_IMM   = 7'h13;
  localparam logic [6:0] OPC_LOAD  = 7'h03;
  localparam logic [6:0] OPC_STORE = 7'h23;
  localparam logic [6:0] OPC_LUI   = 7'h37;
  localparam logic [6:0] OPC_AUIPC = 7'h17;
  localparam logic [6:0] OPC_JAL   = 7'h6F;
  localparam logic [6:0] OPC_JALR  = 7'h67;
  localparam logic [6:0] OPC_BR    = 7'h63;
  localparam logic [6:0] OPC_SYS   = 7'h73;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      op1;
    logic [31:0]      op2;
    logic [31:0]      imm;
    logic [31:0]      rs2_data;
    logic [ALU_W-1:0] alu_op;
    logic [4:0]       rd_addr;
    logic             rd_wen;
    logic [2:0]       funct3;
    logic             is_load;
    logic             is_store;
    logic             is_branch;
    logic             is_jal;
    logic             is_jalr;
    logic             ebreak;
    logic             illegal;
  } bundle_t;

  // One-hot index of the funct3-selected base op (add/sll/slt/sltu/xor/srl/or/and).
  function automatic logic [4:0] base_alu_idx(input logic [2:0] f3);
    case (f3)
      3'd0:    return 5'd0;
      3'd1:    return 5'd6;
      3'd2:    return 5'd8;
      3'd3:    return 5'd9;
      3'd4:    return 5'd2;
      3'd5:    return 5'd5;
      3'd6:    return 5'd3;
      3'd7:    return 5'd4;
      default: return 5'd0;
    endcase
  endfunction

  // RV32E only has x0..x15, so bit 4 of an index marks it out of range.
  function automatic logic reg_bad(input logic [4:0] idx);
    return (NR_REG == 16) && idx[4];
  endfunction

  logic [31:0] inst_s;
  logic [6:0]  opc_s;
  logic [6:0]  f7_s;
  logic [2:0]  f3_s;
  logic [4:0]  rd_s;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  logic [17:0] alu_full_s;
  logic        ill_s, use_rs1_s, use_rs2_s, use_rd_s;
  bundle_t     dec_s;
  bundle_t     out_q, out_d, skid_q, skid_d;
  logic        out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic        accept_s;

  assign inst_s  = bus.in_inst;
  assign opc_s   = inst_s[6:0];
  assign f7_s    = inst_s[31:25];
  assign f3_s    = inst_s[14:12];
  assign rd_s    = inst_s[11:7];
  assign rs1_s   = inst_s[19:15];
  assign rs2_s   = inst_s[24:20];
  assign imm_i_s = {{20{inst_s[31]}}, inst_s[31:20]};
  assign imm_s_s = {{20{inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
  assign imm_b_s = {{20{inst_s[31]}}, inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
  assign imm_u_s = {inst_s[31:12], 12'h000};
  assign imm_j_s = {{12{inst_s[31]}}, inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};

  assign bus.rs1_addr = rs1_s;
  assign bus.rs2_addr = rs2_s;

  // Decode the offered instruction into a bundle (operands, op, flags, legality).
  always_comb begin
    dec_s           = '0;
    alu_full_s      = 18'd0;
    ill_s           = 1'b0;
    use_rs1_s       = 1'b0;
    use_rs2_s       = 1'b0;
    use_rd_s        = 1'b0;
    dec_s.pc        = bus.in_pc;
    dec_s.rs2_data  = bus.rs2_data_in;
    dec_s.rd_addr   = rd_s;
    dec_s.funct3    = f3_s;
    dec_s.is_load   = (opc_s == OPC_LOAD);
    dec_s.is_store  = (opc_s == OPC_STORE);
    dec_s.is_branch = (opc_s == OPC_BR);
    dec_s.is_jal    = (opc_s == OPC_JAL);
    dec_s.is_jalr   = (opc_s == OPC_JALR);
    dec_s.ebreak    = (inst_s == 32'h0010_0073);
    case (opc_s)
      OPC_OP: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        use_rd_s  = 1'b1;
        dec_s.op1 = bus.rs1_data_in;
        dec_s.op2 = bus.rs2_data_in;
        case (f7_s)
          7'h00: alu_full_s[base_alu_idx(f3_s)] = 1'b1;
          7'h20: begin
            if (f3_s == 3'd0)      alu_full_s[1] = 1'b1;
            else if (f3_s == 3'd5) alu_full_s[7] = 1'b1;
            else                   ill_s = 1'b1;
          end
          7'h01: begin
            if (M_EXT == 1) alu_full_s[5'd10 + {2'b00, f3_s}] = 1'b1;
            else            ill_s = 1'b1;
          end
          default: ill_s = 1'b1;
        endcase
      end
      OPC_IMM: begin
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
        dec_s.op1 = bus.rs1_data_in;
        dec_s.imm = imm_i_s;
        if (f3_s == 3'd1 || f3_s == 3'd5) begin
          // Shift amount is the raw rs2 field; funct7 picks logical/arithmetic.
          dec_s.op2 = {27'd0, inst_s[24:20]};
          if (f7_s == 7'h00)                     alu_full_s[base_alu_idx(f3_s)] = 1'b1;
          else if (f7_s == 7'h20 && f3_s == 3'd5) alu_full_s[7] = 1'b1;
          else                                    ill_s = 1'b1;
        end else begin
          dec_s.op2 = imm_i_s;
          alu_full_s[base_alu_idx(f3_s)] = 1'b1;
        end
      end
      OPC_LOAD: begin
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
        dec_s.op1 = bus.rs1_data_in;
        dec_s.op2 = imm_i_s;
        dec_s.imm = imm_i_s;
        alu_full_s[0] = 1'b1;
        ill_s = (f3_s == 3'd3) || (f3_s[2:1] == 2'b11);
      end
      OPC_STORE: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        dec_s.op1 = bus.rs1_data_in;
        dec_s.op2 = imm_s_s;
        dec_s.imm = imm_s_s;
        alu_full_s[0] = 1'b1;
        ill_s = (f3_s > 3'd2);
      end
      OPC_LUI: begin
        use_rd_s  = 1'b1;
        dec_s.op2 = imm_u_s;
        dec_s.imm = imm_u_s;
        alu_full_s[0] = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd_s  = 1'b1;
        dec_s.op1 = bus.in_pc;
        dec_s.op2 = imm_u_s;
        dec_s.imm = imm_u_s;
        alu_full_s[0] = 1'b1;
      end
      OPC_JAL: begin
        // ALU computes the link value pc+4; the target offset rides in imm.
        use_rd_s  = 1'b1;
        dec_s.op1 = bus.in_pc;
        dec_s.op2 = 32'd4;
        dec_s.imm = imm_j_s;
        alu_full_s[0] = 1'b1;
      end
      OPC_JALR: begin
        use_rs1_s = 1'b1;
        use_rd_s  = 1'b1;
        dec_s.op1 = bus.in_pc;
        dec_s.op2 = 32'd4;
        dec_s.imm = imm_i_s;
        alu_full_s[0] = 1'b1;
        ill_s = (f3_s != 3'd0);
      end
      OPC_BR: begin
        use_rs1_s = 1'b1;
        use_rs2_s = 1'b1;
        dec_s.op1 = bus.rs1_data_in;
        dec_s.op2 = bus.rs2_data_in;
        dec_s.imm = imm_b_s;
        case (f3_s)
          3'd0, 3'd1: alu_full_s[1] = 1'b1;
          3'd4, 3'd5: alu_full_s[8] = 1'b1;
          3'd6, 3'd7: alu_full_s[9] = 1'b1;
          default:    ill_s = 1'b1;
        endcase
      end
      OPC_SYS: ill_s = !dec_s.ebreak;
      default: ill_s = 1'b1;
    endcase
    dec_s.illegal = ill_s || (use_rs1_s && reg_bad(rs1_s)) ||
                    (use_rs2_s && reg_bad(rs2_s)) || (use_rd_s && reg_bad(rd_s));
    dec_s.alu_op  = dec_s.illegal ? '0 : alu_full_s[ALU_W-1:0];
    dec_s.rd_wen  = use_rd_s && (rd_s != 5'd0) && !dec_s.illegal;
  end

  // in_ready depends only on registered state (and reset), never on out_ready.
  assign bus.in_ready = rst && !skid_valid_q;
  assign accept_s     = bus.in_valid && bus.in_ready;

  // Two-slot buffer next state: flush wins, SKID refills OUT before new entries.
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || bus.out_ready) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept_s) begin
        out_d       = dec_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_s) begin
      skid_d       = dec_s;
      skid_valid_d = 1'b1;
    end else begin
      skid_valid_d = skid_valid_q;
    end
  end

  // Slot registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_pc        = out_q.pc;
  assign bus.out_op1       = out_q.op1;
  assign bus.out_op2       = out_q.op2;
  assign bus.out_imm       = out_q.imm;
  assign bus.out_rs2_data  = out_q.rs2_data;
  assign bus.out_alu_op    = out_q.alu_op;
  assign bus.out_rd_addr   = out_q.rd_addr;
  assign bus.out_rd_wen    = out_q.rd_wen;
  assign bus.out_funct3    = out_q.funct3;
  assign bus.out_is_load   = out_q.is_load;
  assign bus.out_is_store  = out_q.is_store;
  assign bus.out_is_branch = out_q.is_branch;
  assign bus.out_is_jal    = out_q.is_jal;
  assign bus.out_is_jalr   = out_q.is_jalr;
  assign bus.out_ebreak    = out_q.ebreak;
  assign bus.out_illegal   = out_q.illegal;
  // Retirement strobe for ebreak(); a flushed entry never retires.
  assign bus.ebreak_call   = out_valid_q && bus.out_ready && out_q.ebreak && !bus.flush;
endmodule

// File: tb/tb_ysyx_24110026_decode_stage.sv
module tb_ysyx_24110026_decode_stage;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] rs2_data;
    logic [17:0] alu_op;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        ebreak;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_pc, in_inst;
  logic [31:0] rf [32];
  int          checks = 0;
  int          errors = 0;
  int          calls [2];
  exp_t        q [2][$];
  logic [31:0] seen [$];

  always #5 clk = ~clk;

  ysyx_24110026_decode_stage_if #(.ALU_W(10)) if_e ();
  ysyx_24110026_decode_stage_if #(.ALU_W(18)) if_i ();

  ysyx_24110026_decode_stage #(.NR_REG(16), .M_EXT(0)) u_e (.clk(clk), .rst(rst), .bus(if_e));
  ysyx_24110026_decode_stage #(.NR_REG(32), .M_EXT(1)) u_i (.clk(clk), .rst(rst), .bus(if_i));

  assign if_e.in_valid = in_valid;   assign if_i.in_valid = in_valid;
  assign if_e.in_pc = in_pc;         assign if_i.in_pc = in_pc;
  assign if_e.in_inst = in_inst;     assign if_i.in_inst = in_inst;
  assign if_e.flush = flush;         assign if_i.flush = flush;
  assign if_e.out_ready = out_ready; assign if_i.out_ready = out_ready;
  assign if_e.rs1_data_in = rf[if_e.rs1_addr];
  assign if_e.rs2_data_in = rf[if_e.rs2_addr];
  assign if_i.rs1_data_in = rf[if_i.rs1_addr];
  assign if_i.rs2_data_in = rf[if_i.rs2_addr];

  exp_t obs [2];
  logic rdy_obs [2], ov_obs [2], ebk_obs [2];
  assign obs[0] = {if_e.out_pc, if_e.out_op1, if_e.out_op2, if_e.out_imm, if_e.out_rs2_data,
                   8'd0, if_e.out_alu_op, if_e.out_rd_addr, if_e.out_rd_wen, if_e.out_funct3,
                   if_e.out_is_load, if_e.out_is_store, if_e.out_is_branch, if_e.out_is_jal,
                   if_e.out_is_jalr, if_e.out_ebreak, if_e.out_illegal};
  assign obs[1] = {if_i.out_pc, if_i.out_op1, if_i.out_op2, if_i.out_imm, if_i.out_rs2_data,
                   if_i.out_alu_op, if_i.out_rd_addr, if_i.out_rd_wen, if_i.out_funct3,
                   if_i.out_is_load, if_i.out_is_store, if_i.out_is_branch, if_i.out_is_jal,
                   if_i.out_is_jalr, if_i.out_ebreak, if_i.out_illegal};
  assign rdy_obs[0] = if_e.in_ready;    assign rdy_obs[1] = if_i.in_ready;
  assign ov_obs[0]  = if_e.out_valid;   assign ov_obs[1]  = if_i.out_valid;
  assign ebk_obs[0] = if_e.ebreak_call; assign ebk_obs[1] = if_i.ebreak_call;

  // Reference decode: d=0 is RV32E without M, d=1 is RV32I with M.
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc, input int d);
    exp_t e;
    int   idx;
    int   tbl [8];
    bit   ill, u1, u2, ud;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] r1, r2, ii, is_, ib, iu, ij;
    tbl = '{0, 6, 8, 9, 2, 5, 3, 4};
    opc = inst[6:0]; f3 = inst[14:12]; f7 = inst[31:25];
    r1 = rf[inst[19:15]]; r2 = rf[inst[24:20]];
    ii  = {{20{inst[31]}}, inst[31:20]};
    is_ = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    ib  = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    iu  = {inst[31:12], 12'h000};
    ij  = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    e = '0; idx = -1; ill = 0; u1 = 0; u2 = 0; ud = 0;
    e.pc = pc; e.rs2_data = r2; e.rd_addr = inst[11:7]; e.funct3 = f3;
    e.is_load = (opc == 7'h03); e.is_store = (opc == 7'h23); e.is_branch = (opc == 7'h63);
    e.is_jal = (opc == 7'h6F); e.is_jalr = (opc == 7'h67);
    e.ebreak = (inst == 32'h0010_0073);
    case (opc)
      7'h33: begin
        u1 = 1; u2 = 1; ud = 1; e.op1 = r1; e.op2 = r2;
        if (f7 == 7'h00) idx = tbl[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) idx = 1;
        else if (f7 == 7'h20 && f3 == 3'd5) idx = 7;
        else if (f7 == 7'h01 && d == 1) idx = 10 + int'(f3);
        else ill = 1;
      end
      7'h13: begin
        u1 = 1; ud = 1; e.op1 = r1; e.imm = ii;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.op2 = 32'(inst[24:20]);
          if (f7 == 7'h00) idx = tbl[f3];
          else if (f7 == 7'h20 && f3 == 3'd5) idx = 7;
          else ill = 1;
        end else begin
          e.op2 = ii; idx = tbl[f3];
        end
      end
      7'h03: begin u1 = 1; ud = 1; e.op1 = r1; e.op2 = ii; e.imm = ii; idx = 0;
                   ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
      7'h23: begin u1 = 1; u2 = 1; e.op1 = r1; e.op2 = is_; e.imm = is_; idx = 0; ill = (f3 > 3'd2); end
      7'h37: begin ud = 1; e.op2 = iu; e.imm = iu; idx = 0; end
      7'h17: begin ud = 1; e.op1 = pc; e.op2 = iu; e.imm = iu; idx = 0; end
      7'h6F: begin ud = 1; e.op1 = pc; e.op2 = 32'd4; e.imm = ij; idx = 0; end
      7'h67: begin u1 = 1; ud = 1; e.op1 = pc; e.op2 = 32'd4; e.imm = ii; idx = 0; ill = (f3 != 3'd0); end
      7'h63: begin
        u1 = 1; u2 = 1; e.op1 = r1; e.op2 = r2; e.imm = ib;
        if (f3 < 3'd2) idx = 1;
        else if (f3 == 3'd4 || f3 == 3'd5) idx = 8;
        else if (f3 >= 3'd6) idx = 9;
        else ill = 1;
      end
      7'h73: ill = !e.ebreak;
      default: ill = 1;
    endcase
    if (d == 0 && ((u1 && inst[19:15] >= 5'd16) || (u2 && inst[24:20] >= 5'd16) ||
                   (ud && inst[11:7] >= 5'd16))) ill = 1;
    e.illegal = ill;
    if (!ill && idx >= 0) e.alu_op = 18'd1 << idx;
    e.rd_wen = ud && (inst[11:7] != 5'd0) && !ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One clock: compare against the model, advance the model, step the clock.
  task automatic tick();
    logic exp_rdy, exp_call, acc, drain;
    #1;
    for (int d = 0; d < 2; d++) begin
      exp_rdy = rst && (q[d].size() < 2);
      chk($sformatf("in_ready%0d", d), 200'(rdy_obs[d]), 200'(exp_rdy));
      chk($sformatf("out_valid%0d", d), 200'(ov_obs[d]), 200'(q[d].size() != 0));
      if (q[d].size() != 0) chk($sformatf("bundle%0d", d), 200'(obs[d]), 200'(q[d][0]));
      exp_call = (q[d].size() != 0) && out_ready && q[d][0].ebreak && !flush;
      chk($sformatf("ebreak_call%0d", d), 200'(ebk_obs[d]), 200'(exp_call));
      if (ebk_obs[d]) calls[d]++;
      if (d == 0 && ov_obs[0] && out_ready && !flush) seen.push_back(if_e.out_pc);
      acc   = in_valid && exp_rdy;
      drain = (q[d].size() != 0) && out_ready;
      if (!rst || flush) q[d].delete();
      else begin
        if (drain) void'(q[d].pop_front());
        if (acc) q[d].push_back(model(in_inst, in_pc, d));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] opcs [11];
    logic        got_c;
    opcs = '{32'h33, 32'h13, 32'h03, 32'h23, 32'h37, 32'h17, 32'h6F, 32'h67, 32'h63, 32'h73, 32'h7F};
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'd0;
    rf[2] = 32'd5;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_inst = 32'hFFF1_0093;
    calls[0] = 0; calls[1] = 0;
    #2 rst = 1'b0;
    @(negedge clk);
    tick(); tick();
    chk("reset_bundle_e", 200'(obs[0]), 200'd0);
    chk("reset_bundle_i", 200'(obs[1]), 200'd0);
    chk("reset_rs1_addr", 200'(if_e.rs1_addr), 200'd2);
    chk("reset_rs2_addr", 200'(if_e.rs2_addr), 200'd31);
    rst = 1'b1;

    // addi x1,x2,-1 with x2 = 5
    out_ready = 1'b1; in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'hFFF1_0093;
    tick();
    in_valid = 1'b0;
    chk("addi_op1", 200'(if_e.out_op1), 200'd5);
    chk("addi_op2", 200'(if_e.out_op2), 200'hFFFF_FFFF);
    chk("addi_alu", 200'(if_e.out_alu_op), 200'h001);
    chk("addi_rd", 200'(if_e.out_rd_addr), 200'd1);
    chk("addi_wen", 200'(if_e.out_rd_wen), 200'd1);
    tick();

    // addi x17,x0,17: illegal on RV32E, legal on RV32I
    in_valid = 1'b1; in_pc = 32'h8000_0004; in_inst = 32'h0110_0893;
    tick();
    in_valid = 1'b0;
    chk("rv32e_illegal", 200'(if_e.out_illegal), 200'd1);
    chk("rv32e_wen", 200'(if_e.out_rd_wen), 200'd0);
    chk("rv32i_illegal", 200'(if_i.out_illegal), 200'd0);
    chk("rv32i_wen", 200'(if_i.out_rd_wen), 200'd1);
    tick();

    // mul x1,x1,x2
    in_valid = 1'b1; in_pc = 32'h8000_0008; in_inst = 32'h0220_80B3;
    tick();
    in_valid = 1'b0;
    chk("mul_noext_illegal", 200'(if_e.out_illegal), 200'd1);
    chk("mul_ext_alu", 200'(if_i.out_alu_op), 200'h00400);
    chk("mul_ext_illegal", 200'(if_i.out_illegal), 200'd0);
    tick();

    // back-pressure: A, B fill both slots, C must wait
    out_ready = 1'b0; seen.delete();
    in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h0010_0093; tick();
    in_pc = 32'h104; in_inst = 32'h0020_0113; tick();
    chk("bp_in_ready_after_B", 200'(if_e.in_ready), 200'd0);
    in_pc = 32'h108; in_inst = 32'h0030_0193; tick(); tick();
    out_ready = 1'b1; got_c = 1'b0;
    for (int i = 0; i < 8 && !got_c; i++) begin
      got_c = if_e.in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("bp_C_accepted", 200'(got_c), 200'd1);
    tick(); tick(); tick();
    chk("bp_count", 200'(seen.size()), 200'd3);
    if (seen.size() == 3) chk("bp_order", {104'd0, seen[0], seen[1], seen[2]}, {104'd0, 32'h100, 32'h104, 32'h108});

    // flush with both slots full while offering D
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h1F0; in_inst = 32'h0040_0213; tick();
    in_pc = 32'h1F4; in_inst = 32'h0050_0293; tick();
    in_pc = 32'h200; in_inst = 32'h0060_0313; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 200'(if_e.out_valid), 200'd0);
    chk("flush_in_ready", 200'(if_e.in_ready), 200'd1);
    seen.delete(); out_ready = 1'b1;
    tick(); tick(); tick();
    chk("flush_nothing_emerges", 200'(seen.size()), 200'd0);

    // ebreak stalled 3 cycles, then retired
    calls[0] = 0; calls[1] = 0; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h0010_0073; tick();
    in_valid = 1'b0; tick(); tick(); tick();
    out_ready = 1'b1; tick(); tick(); tick();
    chk("ebreak_calls_e", 200'(calls[0]), 200'd1);
    chk("ebreak_calls_i", 200'(calls[1]), 200'd1);

    // ebreak flushed during the stall
    calls[0] = 0; calls[1] = 0; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h304; tick();
    in_valid = 1'b0; tick();
    flush = 1'b1; tick();
    flush = 1'b0; out_ready = 1'b1; tick(); tick();
    chk("ebreak_flushed_calls", 200'(calls[0] + calls[1]), 200'd0);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      in_inst = $urandom;
      in_inst[6:0] = opcs[$urandom_range(0, 10)][6:0];
      if (in_inst[6:0] == 7'h33 || in_inst[6:0] == 7'h13) begin
        case ($urandom_range(0, 3))
          0: in_inst[31:25] = 7'h00;
          1: in_inst[31:25] = 7'h20;
          2: in_inst[31:25] = 7'h01;
          default: in_inst[31:25] = in_inst[31:25];
        endcase
      end
      if ($urandom_range(0, 1) == 0) begin
        in_inst[11] = 1'b0; in_inst[19] = 1'b0; in_inst[24] = 1'b0;
      end
      if ($urandom_range(0, 15) == 0) in_inst = 32'h0010_0073;
      in_pc     = $urandom & 32'hFFFF_FFFC;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
